// File: rtl/servant_uart_rx_pkg.sv
// servant_uart_pkg: shared FSM state type, register indices and STATUS bit positions for the UART receiver
package servant_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;
  localparam int ST_VALID = 0;
  localparam int ST_OVR   = 1;
  localparam int ST_FERR  = 2;
  localparam int ST_FULL  = 3;
endpackage

// File: rtl/servant_uart_rx_fifo.sv
// servant_uart_rx_fifo: synchronous FIFO; a push while full succeeds when a pop happens in the same cycle
module servant_uart_rx_fifo #(
  parameter int depth = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_empty,
  output logic       o_full
);
  localparam int AW = $clog2(depth);
  logic [7:0]  r_mem [depth];
  logic [AW:0] r_wp, r_rp;
  logic        w_wr, w_rd;
  assign o_empty = r_wp == r_rp;
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_wr    = i_push & (~o_full | i_pop);
  assign w_rd    = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp[AW-1:0]] <= i_data;
endmodule

// File: rtl/servant_uart_rx.sv
// servant_uart_rx: 8N1 serial receiver with a Wishbone DATA/STATUS slave; define
// SERVANT_UART_RX_FIFO_EN to replace the single holding register with a FIFO
module servant_uart_rx
  import servant_uart_pkg::*;
#(
  parameter int clks_per_bit = 87,
  parameter int fifo_depth   = 4
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        i_rx,
  input  logic        i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_irq
);
  localparam logic [15:0] HALF = 16'(clks_per_bit / 2 - 1);
  localparam logic [15:0] FULL = 16'(clks_per_bit - 1);
  state_t      r_state;
  logic [1:0]  r_sync;
  logic [15:0] r_cnt;
  logic [2:0]  r_bitidx;
  logic [7:0]  r_shreg;
  logic        r_ovr, r_ferr, r_ack;
  logic [31:0] r_rdt;
  logic        w_rx, w_push, w_ferr_set, w_ovr_set, w_req, w_pop, w_valid, w_full;
  logic [1:0]  w_clr;
  logic [7:0]  w_head;
  logic [31:0] w_status;
  logic        w_unused;
  assign w_unused   = ^{i_wb_dat[31:3], i_wb_dat[0]};
  assign w_rx       = r_sync[1];
  assign w_push     = (r_state == STOP) && (r_cnt == '0) && w_rx;
  assign w_ferr_set = (r_state == STOP) && (r_cnt == '0) && !w_rx;
  assign w_req      = i_wb_cyc & ~r_ack;
  assign w_pop      = w_req & ~i_wb_we & (i_wb_adr == REG_DATA) & w_valid;
  assign w_clr      = {2{w_req & i_wb_we & (i_wb_adr == REG_STATUS)}} & i_wb_dat[2:1];
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_sync   <= 2'b11;
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bitidx <= '0;
      r_shreg  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_rx};
      case (r_state)
        IDLE: if (!w_rx) begin
          r_cnt   <= HALF;
          r_state <= START;
        end
        START: if (r_cnt != '0) r_cnt <= r_cnt - 16'd1;
        else if (!w_rx) begin
          r_cnt    <= FULL;
          r_bitidx <= '0;
          r_state  <= DATA;
        end else r_state <= IDLE;
        DATA: if (r_cnt != '0) r_cnt <= r_cnt - 16'd1;
        else begin
          r_shreg  <= {w_rx, r_shreg[7:1]};
          r_cnt    <= FULL;
          r_bitidx <= r_bitidx + 3'd1;
          if (r_bitidx == 3'd7) r_state <= STOP;
        end
        STOP: if (r_cnt != '0) r_cnt <= r_cnt - 16'd1;
        else r_state <= w_rx ? IDLE : WAIT_HIGH;
        WAIT_HIGH: if (w_rx) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef SERVANT_UART_RX_FIFO_EN
  logic w_empty;
  servant_uart_rx_fifo #(.depth(fifo_depth)) u_fifo (
    .clk(wb_clk), .rst(wb_rst), .i_push(w_push), .i_pop(w_pop), .i_data(r_shreg),
    .o_data(w_head), .o_empty(w_empty), .o_full(w_full)
  );
  assign w_valid   = ~w_empty;
  assign w_ovr_set = w_push & w_full & ~w_pop;
`else
  localparam int unused_depth = fifo_depth;
  logic [7:0] r_hold;
  logic       r_valid;
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_hold  <= '0;
      r_valid <= 1'b0;
    end else if (w_push && (!r_valid || w_pop)) begin
      r_hold  <= r_shreg;
      r_valid <= 1'b1;
    end else if (w_pop) r_valid <= 1'b0;
  end
  assign w_head    = r_hold;
  assign w_valid   = r_valid;
  assign w_full    = 1'b0;
  assign w_ovr_set = w_push & r_valid & ~w_pop;
`endif
  always_comb begin
    w_status           = '0;
    w_status[ST_VALID] = w_valid;
    w_status[ST_OVR]   = r_ovr;
    w_status[ST_FERR]  = r_ferr;
    w_status[ST_FULL]  = w_full;
  end
  // a new error event wins over a same-cycle write-1-to-clear
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
      r_ack  <= 1'b0;
      r_rdt  <= '0;
    end else begin
      r_ovr  <= (r_ovr & ~w_clr[0]) | w_ovr_set;
      r_ferr <= (r_ferr & ~w_clr[1]) | w_ferr_set;
      r_ack  <= w_req;
      if (w_req && !i_wb_we) r_rdt <= (i_wb_adr == REG_STATUS) ? w_status : {24'h0, w_head};
    end
  end
  assign o_wb_ack = r_ack;
  assign o_wb_rdt = r_rdt;
  assign o_irq    = w_valid;
endmodule
